// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request arbiter: default widths, FSM
// state encoding and the tag-width helper.
package cordic_pkg;

  localparam int CORDIC_DW   = 32;
  localparam int CORDIC_NREQ = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_IDLE  = 2'd2
  } state_t;

  // Requester IDs need at least one bit, even when only one requester exists.
  function automatic int tag_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int TAG_W = tag_width(CORDIC_NREQ);

endpackage

// File: rtl/cordic_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty. A push into a
// full FIFO is accepted when a pop happens in the same cycle.
module cordic_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin sharing of one CORDIC core among NREQ requesters; results return
// to their owners in strict issue order, with credits bounding outstanding ops.
module cordic_req_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ  = CORDIC_NREQ,
  parameter int DW    = CORDIC_DW,
  parameter int DEPTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     in_interface,
  output logic              valid_in_interface,
  input  logic [DW-1:0]     out_interface,
  input  logic              valid_out_interface,
  input  logic              flush,
  output logic              idle,
  output logic              overflow_err
);

  localparam int TW = tag_width(NREQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(DEPTH) + 1;

  state_t          state, state_nxt;
  logic [TW-1:0]   rr_ptr;
  logic [CW-1:0]   credits;
  logic            grant;
  logic [TW-1:0]   gnt_idx;
  logic [TW-1:0]   tag_head;
  logic            tag_full, tag_empty;
  logic [NW-1:0]   tag_count;
  logic            res_full, res_empty;
  logic [NW-1:0]   res_count;
  logic            res_pop, res_push, res_err;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    int idx;
    req_ready = '0;
    grant     = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (!HRESET && state == S_RUN && credits != '0 && !tag_full) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant && req_valid[idx[TW-1:0]]) begin
          grant   = 1'b1;
          gnt_idx = idx[TW-1:0];
        end
      end
      if (grant) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (!HRESET && !res_empty && !tag_empty) rsp_valid[tag_head] = 1'b1;
  end

  assign res_pop  = |(rsp_valid & rsp_ready);
  // A result needs an issued tag that has no result yet; a full FIFO only takes it if a pop frees a slot.
  assign res_err  = valid_out_interface && ((res_full && !res_pop) || (tag_count <= res_count));
  assign res_push = valid_out_interface && !res_err;

  cordic_sync_fifo #(.W(TW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (grant),
    .pop   (res_pop),
    .din   (gnt_idx),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  cordic_sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (res_push),
    .pop   (res_pop),
    .din   (out_interface),
    .dout  (rsp_data),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    case (state)
      S_RUN: begin
        idle = (credits == CW'(DEPTH)) && !(|req_valid);
        if (flush) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        idle = (credits == CW'(DEPTH));
        if (credits == CW'(DEPTH)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        idle = 1'b1;
        if (!flush) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
    if (HRESET) idle = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state              <= S_RUN;
      rr_ptr             <= '0;
      credits            <= CW'(DEPTH);
      valid_in_interface <= 1'b0;
      in_interface       <= '0;
      overflow_err       <= 1'b0;
    end else begin
      state              <= state_nxt;
      valid_in_interface <= grant;
      if (grant) begin
        rr_ptr       <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        in_interface <= req_data[int'(gnt_idx)*DW +: DW];
      end
      if (grant && !res_pop)      credits <= credits - 1'b1;
      else if (!grant && res_pop) credits <= credits + 1'b1;
      if (res_err) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Bench for cordic_req_arbiter: a transaction-level model predicts grants,
// issue data and in-order returns; scoreboard queues feed independent monitors.
module tb_cordic_req_arbiter;

  localparam int NREQ  = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0]     rsp_data, in_interface;
  logic [DW-1:0]     out_interface = '0;
  logic              valid_out_interface = 1'b0;
  logic              valid_in_interface, flush, idle, overflow_err;

  int total = 0;
  int bad   = 0;

  cordic_req_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .HCLK                (HCLK),
    .HRESET              (HRESET),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_ready           (rsp_ready),
    .in_interface        (in_interface),
    .valid_in_interface  (valid_in_interface),
    .out_interface       (out_interface),
    .valid_out_interface (valid_out_interface),
    .flush               (flush),
    .idle                (idle),
    .overflow_err        (overflow_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    int           tag;
    logic [DW-1:0] data;
  } rsp_t;

  typedef enum {M_RUN, M_DRAIN, M_IDLE} mode_t;

  // Reference model: owner order of outstanding ops, buffered results, mode.
  int            m_rr = 0;
  int            m_out = 0;
  mode_t         m_mode = M_RUN;
  bit            m_err = 1'b0;
  int            m_pending[$];
  rsp_t          m_fifo[$];

  logic [DW-1:0] sb_issue[$];
  rsp_t          sb_rsp[$];

  logic [DW-1:0] core_q[$];
  int            core_due[$];
  logic [DW-1:0] core_override[$];
  bit            inject = 1'b0;
  int            cyc = 0;

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (HRESET) begin
      sb_issue.delete();
      sb_rsp.delete();
      core_q.delete();
      core_due.delete();
    end
  end

  always @(negedge HCLK) begin
    int            g;
    int            out0;
    bit            pop;
    bit            full0;
    bit            exp_idle;
    logic [NREQ-1:0] exp_ready, exp_rsp;
    rsp_t          r;
    g = -1; pop = 1'b0; exp_ready = '0; exp_rsp = '0; exp_idle = 1'b1;
    if (HRESET) begin
      check("reset_req_ready", req_ready, '0);
      check("reset_rsp_valid", rsp_valid, '0);
      check("reset_idle", idle, 1'b1);
      m_rr = 0; m_out = 0; m_mode = M_RUN; m_err = 1'b0;
      m_pending.delete();
      m_fifo.delete();
    end else begin
      out0  = m_out;
      full0 = (m_fifo.size() == DEPTH);
      if (m_mode == M_RUN && m_out < DEPTH)
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_rr + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      if (g >= 0) exp_ready[g] = 1'b1;
      if (m_fifo.size() > 0) begin
        exp_rsp[m_fifo[0].tag] = 1'b1;
        pop = rsp_ready[m_fifo[0].tag];
      end
      case (m_mode)
        M_RUN:   exp_idle = (m_out == 0) && (req_valid == '0);
        M_DRAIN: exp_idle = (m_out == 0);
        default: exp_idle = 1'b1;
      endcase
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_rsp);
      check("idle", idle, exp_idle);
      check("overflow_err", overflow_err, m_err);

      if (pop) begin
        void'(m_fifo.pop_front());
        m_out--;
      end
      if (valid_out_interface) begin
        if ((full0 && !pop) || m_pending.size() == 0) m_err = 1'b1;
        else begin
          r.tag  = m_pending.pop_front();
          r.data = out_interface;
          m_fifo.push_back(r);
          sb_rsp.push_back(r);
        end
      end
      if (g >= 0) begin
        m_pending.push_back(g);
        m_out++;
        m_rr = (g + 1) % NREQ;
        sb_issue.push_back(req_data[g*DW +: DW]);
      end
      case (m_mode)
        M_RUN:   if (flush) m_mode = M_DRAIN;
        M_DRAIN: if (out0 == 0) m_mode = M_IDLE;
        default: if (!flush) m_mode = M_RUN;
      endcase
    end
  end

  // Issue monitor: every operand strobe must match the oldest predicted grant.
  always @(negedge HCLK) begin
    if (valid_in_interface) begin
      if (sb_issue.size() == 0) check("issue_unexpected", valid_in_interface, 1'b0);
      else check("in_interface", in_interface, sb_issue.pop_front());
    end
  end

  // Response monitor: each consumed result must be the oldest predicted return.
  always @(negedge HCLK) begin
    rsp_t e;
    if (!HRESET && |(rsp_valid & rsp_ready)) begin
      if (sb_rsp.size() == 0) check("rsp_unexpected", rsp_valid, '0);
      else begin
        e = sb_rsp.pop_front();
        check("rsp_owner", rsp_valid, 64'd1 << e.tag);
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  // Core stand-in: in-order pipeline with 1..4 cycle latency.
  always @(negedge HCLK) begin
    logic [DW-1:0] res;
    if (valid_in_interface) begin
      if (core_override.size() > 0) res = core_override.pop_front();
      else res = core_fn(in_interface);
      core_q.push_back(res);
      core_due.push_back(cyc + int'($urandom_range(1, 4)));
    end
  end

  always @(posedge HCLK) begin
    #1;
    valid_out_interface = 1'b0;
    out_interface       = $urandom;
    if (inject) begin
      valid_out_interface = 1'b1;
      out_interface       = 32'hDEAD_BEEF;
      inject              = 1'b0;
    end else if (core_q.size() > 0 && core_due[0] <= cyc) begin
      valid_out_interface = 1'b1;
      out_interface       = core_q.pop_front();
      void'(core_due.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int last_pop;
    int idle_at;

    HRESET    = 1'b1;
    req_valid = 2'b11;
    req_data  = {32'h2222_0001, 32'h1111_0000};
    rsp_ready = '0;
    flush     = 1'b0;

    // Reset with both requesters asking; first grant afterwards goes to req 0.
    step(2);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("first_grant_req0", req_ready, 2'b01);
    step(1);

    // Round robin with both requesters valid.
    rsp_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      req_data = {$urandom, $urandom};
      step(1);
    end
    req_valid = '0;
    step(12);

    // Issue order: req0 then req1, core answers 0xA1 then 0xA2.
    rsp_ready = '0;
    core_override.push_back(32'hA1);
    core_override.push_back(32'hA2);
    req_data  = {32'h22, 32'h11};
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b10;
    step(1);
    req_valid = '0;
    step(10);
    @(negedge HCLK);
    check("order_first_owner", rsp_valid, 2'b01);
    check("order_first_data", rsp_data, 32'hA1);
    step(1);
    rsp_ready = 2'b01;
    step(1);
    rsp_ready = '0;
    @(negedge HCLK);
    check("order_second_owner", rsp_valid, 2'b10);
    check("order_second_data", rsp_data, 32'hA2);
    step(1);
    rsp_ready = 2'b11;
    step(4);

    // Credit limit: nothing consumed, req0 always valid.
    rsp_ready = '0;
    req_valid = 2'b01;
    n = 0;
    repeat (24) begin
      @(negedge HCLK);
      if (req_ready[0]) n++;
      step(1);
    end
    check("credit_limit_grants", n, DEPTH);
    rsp_ready = 2'b01;
    n = 0;
    @(negedge HCLK);
    if (req_ready[0]) n++;
    step(1);
    rsp_ready = '0;
    repeat (9) begin
      @(negedge HCLK);
      if (req_ready[0]) n++;
      step(1);
    end
    check("one_pop_one_grant", n, 1);
    req_valid = '0;
    rsp_ready = 2'b11;
    step(20);

    // Flush with three ops outstanding.
    rsp_ready = '0;
    req_valid = 2'b01;
    step(3);
    req_valid = '0;
    flush     = 1'b1;
    step(1);
    req_valid = 2'b11;
    n = 0;
    repeat (10) begin
      @(negedge HCLK);
      if (|req_ready) n++;
      step(1);
    end
    check("flush_no_grants", n, 0);
    rsp_ready = 2'b11;
    last_pop  = -1;
    idle_at   = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge HCLK);
      if (idle && idle_at < 0) idle_at = c;
      if (|(rsp_valid & rsp_ready)) last_pop = c;
      step(1);
    end
    check("flush_idle_after_last_pop", idle_at - last_pop, 1);
    flush     = 1'b0;
    req_valid = '0;
    step(3);

    // Spurious core result: sticky error, nothing buffered.
    inject = 1'b1;
    step(3);
    @(negedge HCLK);
    check("overflow_set", overflow_err, 1'b1);
    check("overflow_no_rsp", rsp_valid, '0);
    step(5);
    @(negedge HCLK);
    check("overflow_sticky", overflow_err, 1'b1);
    step(1);
    inject = 1'b1;
    HRESET = 1'b1;
    step(2);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("overflow_cleared_by_reset", overflow_err, 1'b0);
    step(1);

    // Random traffic with flushes and one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      req_valid    = NREQ'($urandom);
      req_data     = {$urandom, $urandom};
      rsp_ready[0] = ($urandom_range(0, 9) < 7);
      rsp_ready[1] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) flush = ~flush;
      HRESET = (i == 700 || i == 701);
      step(1);
    end
    HRESET    = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    rsp_ready = 2'b11;
    step(30);
    @(negedge HCLK);
    check("final_idle", idle, 1'b1);
    check("final_issue_drained", sb_issue.size(), 0);
    check("final_rsp_drained", sb_rsp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
